fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined RV32I core. It is the producer of the 65-bit fetch/decode pipeline register consumed by the decode stage.
- Holds the PC and drives the instruction-memory address.
- Predicts branches with a direct-mapped BTB carrying 2-bit saturating counters.
- Packs {instruction, pc, pred} into the pipeline register.
- Accepts mispredict redirects and predictor training from execute.

Parameters:
BTB_ENTRIES, 16, number of BTB entries; power of two, ≥2.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IDX_BITS, $clog2(BTB_ENTRIES), BTB index width (derived; do not override).

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
stall  input  1  hazard stall; hold PC and fetch_dec_reg
flush  input  1  squash: load bubble into fetch_dec_reg
redirect_en  input  1  execute detected a mispredict
redirect_pc  input  32  correct next PC
update_en  input  1  execute resolved a branch/jump this cycle
update_pc  input  32  PC of the resolved branch
update_taken  input  1  actual branch outcome
update_target  input  32  actual taken target
imem_addr  output  32  instruction memory address (= pc)
imem_rdata  input  32  instruction word; combinational, same cycle
fetch_dec_reg  output  65  {instruction[64:33], pc[32:1], pred[0]}

Behaviour:
- Reset (rstn=0, asynchronous):
  - pc <= RESET_PC.
  - fetch_dec_reg <= 0.
  - All BTB valid bits <= 0, all counters <= 2'b01 (weakly not-taken).
  - Reset mid-operation aborts everything; the first fetch after release is RESET_PC.
- Lookup (combinational on current pc):
  - idx = pc[IDX_BITS+1:2], tag = pc[31:IDX_BITS+2].
  - hit = valid[idx] & (tag_mem[idx] == tag).
  - pred = hit & ctr[idx][1].
  - next_pc = pred ? target[idx] : pc + 32'd4. The add wraps modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.
- PC register, priority order:
  1. redirect_en: pc <= redirect_pc. This applies even when stall=1.
  2. stall: pc holds.
  3. Otherwise: pc <= next_pc.
- fetch_dec_reg update, priority order. This mirrors the consumer's stall-over-flush rule.
  1. stall: hold.
  2. flush or redirect_en: load all zeros. This is a bubble; decode treats instruction 0 as non-writing.
  3. Otherwise: load {imem_rdata, pc, pred}.
- Latency: an instruction at PC p appears in fetch_dec_reg one clock after pc==p with stall=0.
- BTB training (synchronous, when update_en=1; u_idx and u_tag are derived from update_pc):
  - Hit and taken: ctr <= sat_inc(ctr); target <= update_target.
  - Hit and not taken: ctr <= sat_dec(ctr).
  - Miss and taken: allocate the entry (overwrite). valid <= 1, tag <= u_tag, target <= update_target, ctr <= 2'b10.
  - Miss and not taken: no change.
  - Counters saturate at 2'b00 and 2'b11 with no wrap.
  - Training is not gated by stall or flush.
- Same-cycle lookup and update on the same index: the lookup sees the pre-update contents. Writes take effect at the next edge; there is no bypass.
- redirect_en and update_en are independent and may coincide. Both take effect.
- The low 2 bits of pc are never altered except via redirect_pc. The block does not check alignment.

Decomposition:
- Shared package pipeline_pkg holds:
  - FETCH_DEC_W = 65, plus field offsets INSTR_LSB = 33, PC_LSB = 1, PRED_BIT = 0.
  - Counter constants: CTR_SNT = 2'b00, CTR_WNT = 2'b01, CTR_WT = 2'b10, CTR_ST = 2'b11.
  - The decode stage reuses these offsets in its unpack.
- One sub-module, branch_predictor. It contains the BTB arrays, lookup, and training, and exposes pred and pred_target.
- fetch_stage itself keeps the PC register, next-PC mux, and pipeline register.

Test Plan:
1. Reset release, imem returns 32'h0000_0013 for every address, no stalls → pc sequence 0, 4, 8. Cycle 1 after release: fetch_dec_reg = {32'h13, 32'h0, 1'b0}.
2. Loop at 0x10. Branch to 0x4: update_en with taken=1, target 0x4.
   - First update → entry allocated with ctr = 10, so the next fetch of 0x10 gives pred = 1 and next pc = 0x4.
   - Two not-taken updates → ctr 10 → 01 → 00; pred = 0 and next pc = 0x14.
3. Saturation: four taken updates on 0x10 → ctr stays 11. One not-taken update → 10, pred still 1.
4. stall=1 for 3 cycles at pc=0x20 → pc and fetch_dec_reg frozen. With stall=1 and flush=1 → register still held. Releasing stall with flush=1 → fetch_dec_reg = 0.
5. redirect_en=1, redirect_pc=0x100, stall=1 in the same cycle → next pc = 0x100 and fetch_dec_reg held. The following unstalled cycle with redirect low → fetch_dec_reg = {imem_rdata, 0x100, pred}.
6. Aliasing and conflicts:
   - update_pc = 0x40 and a lookup at 0x40 in the same cycle → that cycle predicts with old state.
   - A taken update at 0x440 (same idx, different tag, BTB_ENTRIES = 16) evicts the 0x40 entry; 0x40 then misses with pred = 0.
   - rstn pulsed low mid-stream → all entries invalid and pc = RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch/decode pipeline constants: register layout, BTB counter encodings
// and the saturating counter helpers.
package pipeline_pkg;
  localparam int FETCH_DEC_W = 65;
  localparam int INSTR_LSB   = 33;
  localparam int PC_LSB      = 1;
  localparam int PRED_BIT    = 0;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction
endpackage

// File: rtl/fetch_stage_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup on the fetch PC,
// synchronous training from execute. Lookup never sees same-cycle updates.
module branch_predictor
  import pipeline_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_BITS    = $clog2(BTB_ENTRIES)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] lookup_pc,
  output logic        pred,
  output logic [31:0] pred_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target
);
  localparam int TAG_W = 32 - IDX_BITS - 2;

  logic [BTB_ENTRIES-1:0]            valid_q, valid_d;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [BTB_ENTRIES-1:0][31:0]      tgt_q, tgt_d;
  logic [BTB_ENTRIES-1:0][1:0]       ctr_q, ctr_d;

  logic [IDX_BITS-1:0] l_idx, u_idx;
  logic [TAG_W-1:0]    l_tag, u_tag;
  logic                l_hit, u_hit;
  logic                unused_lsb;

  assign unused_lsb = ^{lookup_pc[1:0], update_pc[1:0]};

  assign l_idx       = lookup_pc[IDX_BITS+1:2];
  assign l_tag       = lookup_pc[31:IDX_BITS+2];
  assign l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign pred        = l_hit & ctr_q[l_idx][1];
  assign pred_target = tgt_q[l_idx];

  assign u_idx = update_pc[IDX_BITS+1:2];
  assign u_tag = update_pc[31:IDX_BITS+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if (update_en) begin
      if (u_hit && update_taken) begin
        ctr_d[u_idx] = sat_inc(ctr_q[u_idx]);
        tgt_d[u_idx] = update_target;
      end else if (u_hit) begin
        ctr_d[u_idx] = sat_dec(ctr_q[u_idx]);
      end else if (update_taken) begin
        // Miss-and-taken evicts whatever aliased into this slot.
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = update_target;
        ctr_d[u_idx]   = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= {BTB_ENTRIES{CTR_WNT}};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, predicted next-PC mux and the fetch/decode
// pipeline register {instruction, pc, pred}.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IDX_BITS    = $clog2(BTB_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   redirect_en,
  input  logic [31:0]            redirect_pc,
  input  logic                   update_en,
  input  logic [31:0]            update_pc,
  input  logic                   update_taken,
  input  logic [31:0]            update_target,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [FETCH_DEC_W-1:0] fetch_dec_reg
);
  logic [31:0]            pc_q, pc_d, next_pc, pred_target;
  logic [FETCH_DEC_W-1:0] fdr_q, fdr_d;
  logic                   pred;

  branch_predictor #(.BTB_ENTRIES(BTB_ENTRIES), .IDX_BITS(IDX_BITS)) u_bp (
    .clk           (clk),
    .rstn          (rstn),
    .lookup_pc     (pc_q),
    .pred          (pred),
    .pred_target   (pred_target),
    .update_en     (update_en),
    .update_pc     (update_pc),
    .update_taken  (update_taken),
    .update_target (update_target)
  );

  assign next_pc = pred ? pred_target : pc_q + 32'd4;

  // Redirect wins over stall for the PC, but stall wins over flush/redirect for
  // the pipeline register, matching the decode side's hold rule.
  always_comb begin
    pc_d = next_pc;
    if (redirect_en)  pc_d = redirect_pc;
    else if (stall)   pc_d = pc_q;
  end

  always_comb begin
    fdr_d = '0;
    if (stall) begin
      fdr_d = fdr_q;
    end else if (!(flush || redirect_en)) begin
      fdr_d[INSTR_LSB +: 32] = imem_rdata;
      fdr_d[PC_LSB +: 32]    = pc_q;
      fdr_d[PRED_BIT]        = pred;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q  <= RESET_PC;
      fdr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      fdr_q <= fdr_d;
    end
  end

  assign imem_addr     = pc_q;
  assign fetch_dec_reg = fdr_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: PC sequencing, BTB training/saturation,
// stall/flush/redirect priority, aliasing and mid-stream reset.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, flush, redirect_en, update_en, update_taken;
  logic [31:0] redirect_pc, update_pc, update_target;
  logic [31:0] imem_addr, imem_rdata;
  logic [64:0] fetch_dec_reg;
  logic        mode;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // mode 0: every word is addi x0,x0,0; mode 1: word tagged with its address
  assign imem_rdata = mode ? {imem_addr[23:0], 8'h13} : 32'h0000_0013;

  fetch_stage dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .update_en(update_en), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .fetch_dec_reg(fetch_dec_reg)
  );

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return mode ? {a[23:0], 8'h13} : 32'h0000_0013;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; redirect_en = 0; redirect_pc = 0;
    update_en = 0; update_pc = 0; update_taken = 0; update_target = 0;
  endtask

  task automatic test_reset();
    idle();
    mode = 0;
    rstn = 0;
    #12;
    checks++;
    if (imem_addr !== 32'h0 || fetch_dec_reg !== 65'h0) begin
      failures++;
      $display("FAIL reset_state: pc=%h fdr=%h required pc=0 fdr=0", imem_addr, fetch_dec_reg);
    end
    @(posedge clk); #1;
    rstn = 1;
    step();
    checks++;
    if (imem_addr !== 32'h4 || fetch_dec_reg !== {32'h13, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL first_fetch: pc=%h fdr=%h required pc=4 fdr=%h", imem_addr, fetch_dec_reg,
               {32'h13, 32'h0, 1'b0});
    end
    step();
    checks++;
    if (imem_addr !== 32'h8 || fetch_dec_reg !== {32'h13, 32'h4, 1'b0}) begin
      failures++;
      $display("FAIL second_fetch: pc=%h fdr=%h required pc=8 fdr=%h", imem_addr, fetch_dec_reg,
               {32'h13, 32'h4, 1'b0});
    end
  endtask

  task automatic test_train();
    mode = 1;
    // allocate 0x10 -> 0x4 while redirecting to 0x10
    update_en = 1; update_pc = 32'h10; update_taken = 1; update_target = 32'h4;
    redirect_en = 1; redirect_pc = 32'h10;
    step();
    idle();
    checks++;
    if (fetch_dec_reg !== 65'h0) begin
      failures++;
      $display("FAIL redirect_bubble: fdr=%h required 0", fetch_dec_reg);
    end
    step();
    checks++;
    if (imem_addr !== 32'h4 || fetch_dec_reg !== {instr_at(32'h10), 32'h10, 1'b1}) begin
      failures++;
      $display("FAIL alloc_predict: pc=%h fdr=%h required pc=4 fdr=%h", imem_addr, fetch_dec_reg,
               {instr_at(32'h10), 32'h10, 1'b1});
    end
    // two not-taken updates: 10 -> 01 -> 00
    update_en = 1; update_pc = 32'h10; update_taken = 0;
    step(); step();
    idle();
    step();
    checks++;
    if (imem_addr !== 32'h10) begin
      failures++;
      $display("FAIL seq_to_10: pc=%h required 10", imem_addr);
    end
    step();
    checks++;
    if (imem_addr !== 32'h14 || fetch_dec_reg !== {instr_at(32'h10), 32'h10, 1'b0}) begin
      failures++;
      $display("FAIL untrained: pc=%h fdr=%h required pc=14 fdr=%h", imem_addr, fetch_dec_reg,
               {instr_at(32'h10), 32'h10, 1'b0});
    end
  endtask

  task automatic test_saturate();
    // 00 -> 01 -> 10 -> 11 -> 11, then one not-taken -> 10
    update_en = 1; update_pc = 32'h10; update_taken = 1; update_target = 32'h4;
    repeat (4) step();
    update_taken = 0;
    redirect_en = 1; redirect_pc = 32'h10;
    step();
    idle();
    step();
    checks++;
    if (imem_addr !== 32'h4 || fetch_dec_reg[0] !== 1'b1) begin
      failures++;
      $display("FAIL sat_high: pc=%h pred=%b required pc=4 pred=1", imem_addr, fetch_dec_reg[0]);
    end
    // 10 -> 01: prediction drops
    update_en = 1; update_pc = 32'h10; update_taken = 0;
    redirect_en = 1; redirect_pc = 32'h10;
    step();
    idle();
    step();
    checks++;
    if (imem_addr !== 32'h14 || fetch_dec_reg[0] !== 1'b0) begin
      failures++;
      $display("FAIL sat_dec: pc=%h pred=%b required pc=14 pred=0", imem_addr, fetch_dec_reg[0]);
    end
  endtask

  task automatic test_stall_flush();
    logic [64:0] held;
    redirect_en = 1; redirect_pc = 32'h1c;
    step();
    idle();
    step();
    held = {instr_at(32'h1c), 32'h1c, 1'b0};
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_addr !== 32'h20 || fetch_dec_reg !== held) begin
        failures++;
        $display("FAIL stall_hold[%0d]: pc=%h fdr=%h required pc=20 fdr=%h", i, imem_addr,
                 fetch_dec_reg, held);
      end
    end
    flush = 1;
    step();
    checks++;
    if (imem_addr !== 32'h20 || fetch_dec_reg !== held) begin
      failures++;
      $display("FAIL stall_over_flush: pc=%h fdr=%h required pc=20 fdr=%h", imem_addr,
               fetch_dec_reg, held);
    end
    stall = 0;
    step();
    flush = 0;
    checks++;
    if (imem_addr !== 32'h24 || fetch_dec_reg !== 65'h0) begin
      failures++;
      $display("FAIL flush_bubble: pc=%h fdr=%h required pc=24 fdr=0", imem_addr, fetch_dec_reg);
    end
  endtask

  task automatic test_redirect_stall();
    logic [64:0] held;
    step();
    held = {instr_at(32'h24), 32'h24, 1'b0};
    redirect_en = 1; redirect_pc = 32'h100; stall = 1;
    step();
    idle();
    checks++;
    if (imem_addr !== 32'h100 || fetch_dec_reg !== held) begin
      failures++;
      $display("FAIL redirect_in_stall: pc=%h fdr=%h required pc=100 fdr=%h", imem_addr,
               fetch_dec_reg, held);
    end
    step();
    checks++;
    if (imem_addr !== 32'h104 || fetch_dec_reg !== {instr_at(32'h100), 32'h100, 1'b0}) begin
      failures++;
      $display("FAIL after_redirect: pc=%h fdr=%h required pc=104 fdr=%h", imem_addr,
               fetch_dec_reg, {instr_at(32'h100), 32'h100, 1'b0});
    end
  endtask

  task automatic test_alias_reset();
    redirect_en = 1; redirect_pc = 32'h40;
    step();
    idle();
    // lookup at 0x40 while 0x40 is being allocated: old (miss) state wins
    update_en = 1; update_pc = 32'h40; update_taken = 1; update_target = 32'h80;
    step();
    idle();
    checks++;
    if (imem_addr !== 32'h44 || fetch_dec_reg[0] !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass: pc=%h pred=%b required pc=44 pred=0", imem_addr, fetch_dec_reg[0]);
    end
    redirect_en = 1; redirect_pc = 32'h40;
    step();
    idle();
    step();
    checks++;
    if (imem_addr !== 32'h80 || fetch_dec_reg !== {instr_at(32'h40), 32'h40, 1'b1}) begin
      failures++;
      $display("FAIL alloc_40: pc=%h fdr=%h required pc=80 fdr=%h", imem_addr, fetch_dec_reg,
               {instr_at(32'h40), 32'h40, 1'b1});
    end
    // 0x440 shares index 0 with 0x40 but carries a different tag
    update_en = 1; update_pc = 32'h440; update_taken = 1; update_target = 32'h200;
    redirect_en = 1; redirect_pc = 32'h40;
    step();
    idle();
    step();
    checks++;
    if (imem_addr !== 32'h44 || fetch_dec_reg[0] !== 1'b0) begin
      failures++;
      $display("FAIL evicted_40: pc=%h pred=%b required pc=44 pred=0", imem_addr, fetch_dec_reg[0]);
    end
    redirect_en = 1; redirect_pc = 32'h440;
    step();
    idle();
    step();
    checks++;
    if (imem_addr !== 32'h200 || fetch_dec_reg !== {instr_at(32'h440), 32'h440, 1'b1}) begin
      failures++;
      $display("FAIL alloc_440: pc=%h fdr=%h required pc=200 fdr=%h", imem_addr, fetch_dec_reg,
               {instr_at(32'h440), 32'h440, 1'b1});
    end
    rstn = 0;
    #2;
    checks++;
    if (imem_addr !== 32'h0 || fetch_dec_reg !== 65'h0) begin
      failures++;
      $display("FAIL midreset: pc=%h fdr=%h required pc=0 fdr=0", imem_addr, fetch_dec_reg);
    end
    rstn = 1;
    step();
    checks++;
    if (imem_addr !== 32'h4 || fetch_dec_reg !== {instr_at(32'h0), 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL post_reset_fetch: pc=%h fdr=%h required pc=4 fdr=%h", imem_addr,
               fetch_dec_reg, {instr_at(32'h0), 32'h0, 1'b0});
    end
    redirect_en = 1; redirect_pc = 32'h440;
    step();
    idle();
    step();
    checks++;
    if (imem_addr !== 32'h444 || fetch_dec_reg[0] !== 1'b0) begin
      failures++;
      $display("FAIL btb_cleared: pc=%h pred=%b required pc=444 pred=0", imem_addr,
               fetch_dec_reg[0]);
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_saturate();
    test_stall_flush();
    test_redirect_stall();
    test_alias_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
